user_io_event: RTL
==================

# user_io_event

Downstream consumer of the TCA9555 poller's `o_button[5:0]` and `o_link_pow[3:0]` outputs. It debounces each button bit and detects any change in the combined button/link-power state. Each change is timestamped and queued in a small show-ahead FIFO. Events leave the FIFO over a valid/ready stream toward the host-facing register/stream logic, so single press/release events are not lost between host reads.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 160_000 (10 ms at 16 MHz). Number of consecutive cycles a button bit must differ from its debounced value before that value flips. Must be ≥ 1.
- `FIFO_DEPTH`, default 8. Number of event entries. Must be a power of 2, ≥ 2.
- `TS_WIDTH`, default 32. Width of the timestamp counter.

Ports:
- `i_clk`  in  1  Clock.
- `i_reset`  in  1  Synchronous, active-high reset.
- `i_button`  in  6  Raw button states (1 = pressed).
- `i_link_pow`  in  4  Headstage link power good, one bit per port. Not debounced.
- `o_event_valid`  out  1  FIFO head holds an event.
- `i_event_ready`  in  1  Consumer accepts the head entry.
- `o_event_ts`  out  TS_WIDTH  Timestamp of the head entry.
- `o_event_button`  out  6  Debounced button vector of the head entry.
- `o_event_link_pow`  out  4  Link-power vector of the head entry.
- `o_event_dropped`  out  1  One or more events were dropped before this entry.
- `o_fifo_count`  out  $clog2(FIFO_DEPTH)+1  Current occupancy.

## Operation
- **Debounce, per button bit**
  - A counter runs while the raw bit differs from the debounced bit, and clears to 0 on any cycle where they are equal.
  - When the counter reaches DEBOUNCE_CYCLES−1 while the bit still differs, the debounced bit takes the raw value and the counter clears.
- **Timestamp**
  - Free-running counter, incremented every cycle.
  - Wraps modulo 2^TS_WIDTH with no flag.
- **Change detection**
  - `cur` = {`i_link_pow`, debounced `button`}. `last` = the last pushed vector.
  - If `cur != last`, a push is requested on that cycle and `last <= cur`. Any number of bits changing on the same cycle produces one entry.
  - Entry contents: {`ts`, `button`, `link_pow`, `dropped_sticky`}.
- **FIFO**
  - Show-ahead register array with wrapping read/write pointers and an extra count bit.
  - Pop happens when `o_event_valid && i_event_ready`.
  - When full, a push is dropped, `last` still updates, and `dropped_sticky` sets.
  - `dropped_sticky` clears on the cycle an entry carrying it is written.
  - Full with simultaneous pop and push: both occur and the count is unchanged.
  - Empty with a push: the entry becomes visible on the next cycle. There is no same-cycle bypass.
- **Reset values**
  - All outputs are 0: `o_event_valid` 0, data 0, `o_fifo_count` 0.
  - Debounced bits, `last`, the timestamp, the pointers and `dropped_sticky` are all 0.
  - Reset mid-operation discards all queued entries and in-progress debounce counts.

## Timing
- Raw button edge at cycle N, held stable: the debounced bit flips at the edge ending cycle N+DEBOUNCE_CYCLES−1, the push happens at the next edge, and `o_event_valid` rises on the cycle after that.
  - Total latency is DEBOUNCE_CYCLES+1 cycles from raw change to a visible event, with the FIFO empty.
- Link-power change at cycle N: `o_event_valid` is high at N+2, with the FIFO empty.
- The timestamp captured is the counter value in the cycle the change is detected.
- Stream rules:
  - Data holds stable while `o_event_valid && !i_event_ready`.
  - `o_event_valid` never drops without a pop.
  - Sustained throughput is one entry per cycle.

## Configuration
- `USER_IO_EVENT_TS_EN`
  - Defined: the timestamp counter is built and entries carry `ts`.
  - Undefined: no counter or timestamp storage is built, and `o_event_ts` is tied to 0. All other behaviour is identical.

## Structure
- Shared package holds:
  - Event field widths (6 button, 4 link-power) and the field order of the packed entry.
  - The FIFO pointer-width function.
  - The default DEBOUNCE_CYCLES derived as CLK_RATE_HZ/1000 × 10 ms.
- Sub-module `button_debounce`: single-bit debouncer with parameter DEBOUNCE_CYCLES, instantiated 6 times.
- FIFO and change detection stay inline.

## Test plan
Run with DEBOUNCE_CYCLES=4, FIFO_DEPTH=4, `i_event_ready`=1 unless stated.
- **Debounce reject and accept:** `i_button[0]` high for 3 cycles then low → no event. Then high and held → exactly one event with `o_event_button`=6'b000001, valid 5 cycles after the rise.
- **Simultaneous link changes:** `i_link_pow` 0→4'b1111 at cycle 10 → one event at cycle 12 with `link_pow`=4'hF, `button`=0, `ts`=10.
- **Overflow:** `i_event_ready`=0, then 6 distinct link-power changes → count saturates at 4 and the first 4 entries are kept. Then ready=1 plus a new change → 5th entry has `dropped`=1; later entries have 0.
- **Full with pop and push:** FIFO full, ready=1 and a change on the same cycle → count stays 4, no drop, order preserved.
- **Backpressure:** ready toggles 1/0 each cycle with 3 entries queued → data stable whenever ready=0, and all 3 entries drain in order.
- **Reset mid-queue:** 2 entries queued plus a half-elapsed debounce, then `i_reset` for 1 cycle → `o_event_valid`=0, count 0, no event from the pre-reset partial press. Repeat with `USER_IO_EVENT_TS_EN` undefined → `o_event_ts` always 0.

Source files
------------

// File: rtl/user_io_event_pkg.sv
// Shared definitions for the user I/O event queue: field widths, packed
// entry layout, FIFO pointer sizing and the default debounce interval.
package user_io_event_pkg;

    localparam int BUTTON_W    = 6;
    localparam int LINK_POW_W  = 4;

    // Default debounce interval: 10 ms at the 16 MHz system clock.
    localparam int CLK_RATE_HZ             = 16_000_000;
    localparam int DEBOUNCE_MS             = 10;
    localparam int DEFAULT_DEBOUNCE_CYCLES = CLK_RATE_HZ / 1000 * DEBOUNCE_MS;

    // Non-timestamp part of an entry. Full entry order, MSB to LSB:
    // {ts, button, link_pow, dropped}.
    typedef struct packed {
        logic [BUTTON_W-1:0]   button;
        logic [LINK_POW_W-1:0] link_pow;
        logic                  dropped;
    } event_fields_t;

    // Read/write pointer width for a power-of-2 FIFO depth.
    function automatic int fifo_ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/user_io_event_if.sv
// Event stream from the user I/O event queue toward the host-facing logic.
// master = event producer, slave = consumer.
interface user_io_event_if
    import user_io_event_pkg::*;
#(
    parameter int TS_WIDTH = 32
) ();

    logic                  o_event_valid;
    logic                  i_event_ready;
    logic [TS_WIDTH-1:0]   o_event_ts;
    logic [BUTTON_W-1:0]   o_event_button;
    logic [LINK_POW_W-1:0] o_event_link_pow;
    logic                  o_event_dropped;

    modport master (
        output o_event_valid,
        input  i_event_ready,
        output o_event_ts,
        output o_event_button,
        output o_event_link_pow,
        output o_event_dropped
    );

    modport slave (
        input  o_event_valid,
        output i_event_ready,
        input  o_event_ts,
        input  o_event_button,
        input  o_event_link_pow,
        input  o_event_dropped
    );

endinterface

// File: rtl/user_io_event_button_debounce.sv
// Single-bit debouncer: the output follows the raw input only after the raw
// value has differed from it for DEBOUNCE_CYCLES consecutive cycles.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 160_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_debounced
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_state;

    // Count consecutive disagreeing cycles; flip the state on the last one.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt   <= '0;
            r_state <= 1'b0;
        end else if (i_raw == r_state) begin
            r_cnt   <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= i_raw;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    assign o_debounced = r_state;

endmodule

// File: rtl/user_io_event.sv
// User I/O event queue: debounces buttons, detects any change of the
// {link_pow, button} state and queues timestamped entries in a show-ahead
// FIFO drained over a valid/ready stream.
// Optional feature macro: USER_IO_EVENT_TS_EN (timestamp counter/storage).
module user_io_event
    import user_io_event_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int FIFO_DEPTH      = 8,
    parameter int TS_WIDTH        = 32
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [BUTTON_W-1:0]       i_button,
    input  logic [LINK_POW_W-1:0]     i_link_pow,
    user_io_event_if.master           ev,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_count
);

    localparam int PTR_W = fifo_ptr_width(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [BUTTON_W-1:0]            w_button_db;
    logic [LINK_POW_W-1:0]          r_link_pow;
    logic [LINK_POW_W+BUTTON_W-1:0] w_cur;
    logic [LINK_POW_W+BUTTON_W-1:0] r_last;
    logic                           w_push_req;
    logic                           w_push;
    logic                           w_pop;
    logic                           w_drop;
    logic                           w_full;
    logic                           w_valid;
    logic                           r_dropped_sticky;
    logic [PTR_W-1:0]               r_wr_ptr;
    logic [PTR_W-1:0]               r_rd_ptr;
    logic [CNT_W-1:0]               r_count;
    event_fields_t                  r_mem_fields [FIFO_DEPTH];
    event_fields_t                  w_wr_fields;
    event_fields_t                  w_head;

    for (genvar g = 0; g < BUTTON_W; g++) begin : g_db
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .i_clk      (i_clk),
            .i_reset    (i_reset),
            .i_raw      (i_button[g]),
            .o_debounced(w_button_db[g])
        );
    end

    // Register link power so it enters change detection one cycle after the
    // pin changes, like the debounced buttons which also come from a flop.
    always_ff @(posedge i_clk) begin
        if (i_reset) r_link_pow <= '0;
        else         r_link_pow <= i_link_pow;
    end

    assign w_cur      = {r_link_pow, w_button_db};
    assign w_push_req = (w_cur != r_last);
    assign w_valid    = (r_count != '0);
    assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop      = w_valid && ev.i_event_ready;
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    assign w_wr_fields = '{button: w_button_db, link_pow: r_link_pow,
                           dropped: r_dropped_sticky};

    // Track the last vector seen; it updates even when the push is dropped.
    always_ff @(posedge i_clk) begin
        if (i_reset) r_last <= '0;
        else         r_last <= w_cur;
    end

    // Entry storage; contents are only observed through the read pointer.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem_fields[r_wr_ptr] <= w_wr_fields;
    end

    // Pointers, occupancy and the sticky drop flag.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_count          <= '0;
            r_dropped_sticky <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop)      r_dropped_sticky <= 1'b1;
            else if (w_push) r_dropped_sticky <= 1'b0;
        end
    end

    // Data is forced to 0 while empty so the idle/reset outputs read 0.
    assign w_head              = r_mem_fields[r_rd_ptr];
    assign ev.o_event_valid    = w_valid;
    assign ev.o_event_button   = w_valid ? w_head.button   : '0;
    assign ev.o_event_link_pow = w_valid ? w_head.link_pow : '0;
    assign ev.o_event_dropped  = w_valid ? w_head.dropped  : 1'b0;
    assign o_fifo_count        = r_count;

`ifdef USER_IO_EVENT_TS_EN
    logic [TS_WIDTH-1:0] r_ts;
    logic [TS_WIDTH-1:0] r_mem_ts [FIFO_DEPTH];

    // Free-running timestamp, wraps silently.
    always_ff @(posedge i_clk) begin
        if (i_reset) r_ts <= '0;
        else         r_ts <= r_ts + TS_WIDTH'(1);
    end

    // Timestamp storage alongside the entry fields.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem_ts[r_wr_ptr] <= r_ts;
    end

    assign ev.o_event_ts = w_valid ? r_mem_ts[r_rd_ptr] : '0;
`else
    assign ev.o_event_ts = '0;
`endif

endmodule
